// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response port
// plus the decoded-side instruction queue head.
interface ifu_fetch_queue_if;
   logic        im_req_valid;
   logic        im_req_ready;
   logic [31:0] im_req_addr;
   logic        im_rsp_valid;
   logic [31:0] im_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;

   modport master (
      output im_req_valid, im_req_addr,
      input  im_req_ready, im_rsp_valid, im_rsp_data,
      output out_valid, out_instr, out_pc, out_pc4,
      input  out_ready
   );

   modport slave (
      input  im_req_valid, im_req_addr,
      output im_req_ready, im_rsp_valid, im_rsp_data,
      input  out_valid, out_instr, out_pc, out_pc4,
      output out_ready
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Fetch unit: single-outstanding word fetches into a PC-tagged queue,
// with internal j/br/jr redirect targets and stale-response dropping.
module ifu_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   ifu_fetch_queue_if.master bus,
   input  logic        j_valid,
   input  logic [25:0] j_index,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   input  logic [31:0] redir_base
);
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } qent_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr;
   logic [31:0]   pend_pc;
   logic [31:0]   target;
   logic          req_valid;
   logic          outstanding;
   logic          stale;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   qent_t         q [QDEPTH];

   logic redir;
   logic accept;
   logic rsp;
   logic push;
   logic pop;
   logic issue;
   logic pending;

   always_comb begin
      target = jr_target & ~32'd3;
      if (j_valid)
         target = {redir_base[31:28], j_index, 2'b00};
      else if (br_taken)
         target = redir_base + 32'd4
                + {{14{br_imm[15]}}, br_imm, 2'b00};
   end

   assign redir   = j_valid | br_taken | jr_valid;
   assign accept  = req_valid & bus.im_req_ready;
   assign rsp     = bus.im_rsp_valid & outstanding;
   assign push    = rsp & ~stale & ~redir;
   assign pop     = (count != '0) & bus.out_ready & ~redir;
   assign pending = req_valid | (outstanding & ~bus.im_rsp_valid);
   assign issue   = ~req_valid & ~outstanding & ~stale
                  & ~redir & (count < QFULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         req_valid   <= 1'b0;
         req_addr    <= RESET_PC;
         outstanding <= 1'b0;
         stale       <= 1'b0;
         pend_pc     <= '0;
      end else begin
         if (issue) begin
            req_valid <= 1'b1;
            req_addr  <= fetch_pc;
         end else if (accept) begin
            req_valid <= 1'b0;
         end
         if (accept) begin
            outstanding <= 1'b1;
            pend_pc     <= req_addr;
         end else if (rsp) begin
            outstanding <= 1'b0;
         end
         // a stale request's accept must not advance the new stream
         if (redir)
            fetch_pc <= target;
         else if (accept & ~stale)
            fetch_pc <= fetch_pc + 32'd4;
         if (redir & pending)
            stale <= 1'b1;
         else if (rsp)
            stale <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < QDEPTH; i++)
            q[i] <= '0;
      end else if (redir) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q[wr_ptr] <= '{instr: bus.im_rsp_data, pc: pend_pc};
            wr_ptr    <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)
            count <= count + 1'b1;
         else if (pop & ~push)
            count <= count - 1'b1;
      end
   end

   assign bus.im_req_valid = req_valid;
   assign bus.im_req_addr  = req_addr;
   assign bus.out_valid    = (count != '0);
   assign bus.out_instr    = q[rd_ptr].instr;
   assign bus.out_pc       = q[rd_ptr].pc;
   assign bus.out_pc4      = q[rd_ptr].pc + 32'd4;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: transaction-level model with a memory
// responder, directed scenarios and randomized traffic.
module tb_ifu_fetch_queue;
   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        j_valid, br_taken, jr_valid;
   logic [25:0] j_index;
   logic [15:0] br_imm;
   logic [31:0] jr_target, redir_base;

   ifu_fetch_queue_if bus();

   ifu_fetch_queue #(.RESET_PC(32'h0000_3000), .QDEPTH(QD)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .j_valid(j_valid), .j_index(j_index),
      .br_taken(br_taken), .br_imm(br_imm),
      .jr_valid(jr_valid), .jr_target(jr_target),
      .redir_base(redir_base)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mq[$];
   bit          m_req_valid, m_req_stale, m_out, m_out_stale;
   logic [31:0] m_req_addr, m_out_pc, m_fetch;
   int          m_lat;
   int          cyc;

   int k_ready = 100, k_lat_lo = 1, k_lat_hi = 1;
   int k_ordy = 100, k_spur = 0, k_redir = 0;

   bit          d_go, d_j, d_br, d_jr;
   logic [31:0] d_base, d_jrt;
   logic [25:0] d_idx;
   logic [15:0] d_imm;

   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   int          iss_cyc[$];
   int          stale_rsp_cyc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic void chk(input string name,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      return (acc_log.size() > i) ? acc_log[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] pop_at(input int i);
      return (pop_log.size() > i) ? pop_log[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] tgt();
      if (j_valid)
         return (redir_base & 32'hF000_0000) | (32'(j_index) * 4);
      if (br_taken)
         return redir_base + 4 + 32'($signed(br_imm) * 4);
      return jr_target & ~32'd3;
   endfunction

   task automatic model_init();
      mq.delete();
      m_req_valid = 0; m_req_stale = 0;
      m_out = 0; m_out_stale = 0; m_lat = 0;
      m_req_addr = '0; m_out_pc = '0;
      m_fetch = 32'h0000_3000;
      acc_log.delete(); pop_log.delete(); iss_cyc.delete();
      stale_rsp_cyc = -1;
      cyc = 0;
   endtask

   task automatic check_out();
      chk("req_valid", {31'd0, bus.im_req_valid}, {31'd0, m_req_valid});
      if (m_req_valid)
         chk("req_addr", bus.im_req_addr, m_req_addr);
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("out_pc", bus.out_pc, mq[0]);
         chk("out_instr", bus.out_instr, memf(mq[0]));
         chk("out_pc4", bus.out_pc4, mq[0] + 32'd4);
      end
   endtask

   task automatic drive();
      bus.im_req_ready = ($urandom_range(99) < k_ready);
      bus.out_ready    = ($urandom_range(99) < k_ordy);
      if (m_out && m_lat <= 1) begin
         bus.im_rsp_valid = 1'b1;
         bus.im_rsp_data  = memf(m_out_pc);
      end else begin
         if (m_out) m_lat--;
         bus.im_rsp_valid = !m_out && ($urandom_range(99) < k_spur);
         bus.im_rsp_data  = $urandom;
      end
      j_index = 26'($urandom);
      br_imm = 16'($urandom);
      jr_target = $urandom;
      redir_base = $urandom;
      j_valid = 0; br_taken = 0; jr_valid = 0;
      if (d_go) begin
         d_go = 0;
         j_valid = d_j; br_taken = d_br; jr_valid = d_jr;
         redir_base = d_base; j_index = d_idx;
         br_imm = d_imm; jr_target = d_jrt;
      end else if ($urandom_range(99) < k_redir) begin
         int r;
         r = $urandom_range(1, 7);
         j_valid = r[0]; br_taken = r[1]; jr_valid = r[2];
      end
   endtask

   task automatic update();
      bit redir, acc, rsp, blk, iss;
      int sz;
      logic [31:0] t;
      redir = j_valid || br_taken || jr_valid;
      sz = mq.size();
      acc = m_req_valid && bus.im_req_ready;
      rsp = bus.im_rsp_valid && m_out;
      blk = (m_req_valid && m_req_stale) || (m_out && m_out_stale);
      iss = !m_req_valid && !m_out && sz < QD && !redir && !blk;
      t = tgt();
      if (acc && !m_req_stale && !redir) acc_log.push_back(bus.im_req_addr);
      if (sz > 0 && bus.out_ready && !redir) pop_log.push_back(bus.out_pc);
      if (iss) iss_cyc.push_back(cyc);
      if (rsp && m_out_stale) stale_rsp_cyc = cyc;
      if (redir) mq.delete();
      else begin
         if (sz > 0 && bus.out_ready) void'(mq.pop_front());
         if (rsp && !m_out_stale) mq.push_back(m_out_pc);
      end
      if (m_out && redir && !rsp) m_out_stale = 1;
      if (rsp) m_out = 0;
      if (acc) begin
         m_out = 1;
         m_out_pc = m_req_addr;
         m_out_stale = m_req_stale || redir;
         m_lat = $urandom_range(k_lat_hi, k_lat_lo);
         if (!m_req_stale && !redir) m_fetch += 32'd4;
         m_req_valid = 0;
      end else if (m_req_valid && redir) begin
         m_req_stale = 1;
      end
      if (iss) begin
         m_req_valid = 1;
         m_req_addr = m_fetch;
         m_req_stale = 0;
      end
      if (redir) m_fetch = t;
      cyc++;
   endtask

   task automatic step();
      check_out();
      drive();
      update();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.im_req_ready = 0; bus.im_rsp_valid = 0; bus.im_rsp_data = '0;
      bus.out_ready = 0;
      j_valid = 0; br_taken = 0; jr_valid = 0;
      j_index = '0; br_imm = '0; jr_target = '0; redir_base = '0;
      #1;
      chk("rst_req_valid", {31'd0, bus.im_req_valid}, 32'd0);
      chk("rst_req_addr", bus.im_req_addr, 32'h0000_3000);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_init();
   endtask

   task automatic redirect(input bit j, input bit br, input bit jr,
                           input logic [31:0] base, input logic [25:0] idx,
                           input logic [15:0] imm, input logic [31:0] jrt);
      d_go = 1; d_j = j; d_br = br; d_jr = jr;
      d_base = base; d_idx = idx; d_imm = imm; d_jrt = jrt;
   endtask

   initial begin
      d_go = 0;
      @(negedge clk);
      do_reset();

      // basic streaming
      k_ready = 100; k_lat_lo = 1; k_lat_hi = 1; k_ordy = 100;
      run(14);
      chk("first_req", acc_at(0), 32'h0000_3000);
      chk("stream_pc0", pop_at(0), 32'h0000_3000);
      chk("stream_pc1", pop_at(1), 32'h0000_3004);
      chk("stream_pc2", pop_at(2), 32'h0000_3008);

      // fill with decode stalled, then drain
      do_reset();
      k_ordy = 0;
      run(20);
      chk("full_accepts", acc_log.size(), 32'd4);
      chk("full_req_idle", {31'd0, bus.im_req_valid}, 32'd0);
      chk("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
      k_ordy = 100;
      run(12);
      for (int i = 0; i < 5; i++)
         chk("drain_pc", pop_at(i), 32'h0000_3000 + 32'(i * 4));

      // taken branch backwards
      do_reset();
      run(6);
      acc_log.delete(); pop_log.delete();
      redirect(0, 1, 0, 32'h0000_3010, '0, 16'hFFFC, '0);
      run(12);
      chk("br_req", acc_at(0), 32'h0000_3004);
      chk("br_pop", pop_at(0), 32'h0000_3004);

      // jump beats branch
      acc_log.delete(); pop_log.delete();
      redirect(1, 1, 0, 32'h0000_3020, 26'h0000C00, 16'h0040, '0);
      run(12);
      chk("j_req", acc_at(0), 32'h0000_3000);
      chk("j_pop", pop_at(0), 32'h0000_3000);

      // jr with unaligned register value
      acc_log.delete(); pop_log.delete();
      redirect(0, 0, 1, '0, '0, '0, 32'h0000_4007);
      run(12);
      chk("jr_req", acc_at(0), 32'h0000_4004);
      chk("jr_pop", pop_at(0), 32'h0000_4004);

      // redirect over a slow outstanding fetch
      do_reset();
      k_lat_lo = 5; k_lat_hi = 5;
      for (int i = 0; i < 20 && !m_out; i++) step();
      chk("slow_outstanding", {31'd0, m_out}, 32'd1);
      pop_log.delete(); iss_cyc.delete(); stale_rsp_cyc = -1;
      redirect(0, 0, 1, '0, '0, '0, 32'h0000_5000);
      run(24);
      chk("stale_rsp_seen", {31'd0, stale_rsp_cyc >= 0}, 32'd1);
      chk("reissue_after_rsp",
          {31'd0, iss_cyc.size() > 0 && iss_cyc[0] > stale_rsp_cyc}, 32'd1);
      chk("slow_pop", pop_at(0), 32'h0000_5000);
      k_lat_lo = 1; k_lat_hi = 1;

      // request held while memory not ready
      do_reset();
      k_ready = 0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", {31'd0, bus.im_req_valid}, 32'd1);
         chk("hold_addr", bus.im_req_addr, 32'h0000_3000);
         step();
      end
      k_ready = 100;
      run(6);
      chk("hold_release", acc_at(0), 32'h0000_3000);

      // reset in the middle of traffic
      k_lat_hi = 3; k_ordy = 50;
      run(9);
      #2;
      do_reset();
      k_lat_hi = 1; k_ordy = 100; k_spur = 30;
      run(8);
      chk("post_reset_req", acc_at(0), 32'h0000_3000);
      chk("post_reset_pop", pop_at(0), 32'h0000_3000);

      // randomized traffic
      for (int p = 0; p < 6; p++) begin
         k_ready = $urandom_range(100, 20);
         k_lat_lo = 1;
         k_lat_hi = $urandom_range(6, 1);
         k_ordy = $urandom_range(100, 10);
         k_spur = $urandom_range(20, 0);
         k_redir = $urandom_range(15, 2);
         do_reset();
         run(1500);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
